// File: rtl/pipe_stage_fifo_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo_pkg
// Shared definitions for the inter-stage pipeline buffer.
//   psf_op_e : classification of a cycle's handshake activity, encoded as
//              {push, pop} so it can be formed directly from the two strobes.
// ---------------------------------------------------------------------------
package pipe_stage_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } psf_op_e;

endpackage

// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
// Full-throughput valid/ready buffer between two pipeline stages. Holds up to
// DEPTH words; sustains one word per cycle when the consumer is ready. A
// synchronous flush discards everything stored (used on redirects). With
// BYPASS=1 the block is a pure combinational pass-through.
//
// Parameters
//   WIDTH  : payload width
//   DEPTH  : number of entries (power of two, >= 2)
//   BYPASS : 1 = combinational pass-through, no storage
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active low
//   flush   in   synchronous discard of all stored words
//   s_valid in   upstream word present
//   s_ready out  buffer accepts a word this cycle
//   s_data  in   upstream payload
//   m_valid out  head word valid
//   m_ready in   downstream consumes head
//   m_data  out  head payload (undefined while m_valid=0)
//   count   out  current occupancy
// ---------------------------------------------------------------------------
module pipe_stage_fifo
   import pipe_stage_fifo_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   generate
      if (BYPASS != 0) begin : g_bypass
         // Single-cycle build: no state, so clock, reset and flush are unused.
         logic unused_bypass;
         assign unused_bypass = ^{clk, rst, flush};

         assign s_ready = m_ready;
         assign m_valid = s_valid;
         assign m_data  = s_data;
         assign count   = '0;
      end else begin : g_fifo
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic [PW-1:0]    wp_q, wp_d;
         logic [PW-1:0]    rp_q, rp_d;
         logic [CW-1:0]    cnt_q, cnt_d;
         logic             push, pop;
         psf_op_e          op;

         // Ready/valid come only from registered occupancy, so there is no
         // combinational path from m_ready to s_ready across the stage.
         assign s_ready = (cnt_q != CW'(DEPTH));
         assign m_valid = (cnt_q != '0);
         assign m_data  = mem_q[rp_q];
         assign count   = cnt_q;

         assign push = s_valid & s_ready;
         assign pop  = m_valid & m_ready;
         assign op   = psf_op_e'({push, pop});

         always_comb begin
            wp_d  = wp_q;
            rp_d  = rp_q;
            cnt_d = cnt_q;
            if (flush) begin
               // Redirect: drop all stored words and the one offered this cycle.
               wp_d  = '0;
               rp_d  = '0;
               cnt_d = '0;
            end else begin
               // Pointers wrap naturally; full/empty is decided by cnt alone.
               unique case (op)
                  OP_IDLE: ;
                  OP_PUSH: begin
                     wp_d  = wp_q + PW'(1);
                     cnt_d = cnt_q + CW'(1);
                  end
                  OP_POP: begin
                     rp_d  = rp_q + PW'(1);
                     cnt_d = cnt_q - CW'(1);
                  end
                  OP_BOTH: begin
                     wp_d = wp_q + PW'(1);
                     rp_d = rp_q + PW'(1);
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wp_q  <= '0;
               rp_q  <= '0;
               cnt_q <= '0;
            end else begin
               wp_q  <= wp_d;
               rp_q  <= rp_d;
               cnt_q <= cnt_d;
            end
         end

         // Storage is not reset; a flushed push must not overwrite a slot.
         always_ff @(posedge clk) begin
            if (push && !flush) begin
               mem_q[wp_q] <= s_data;
            end
         end
      end
   endgenerate

endmodule
